vga_timing_pipe: RTL and testbench

//  Parametrised VGA timing and pixel-output pipeline; successor to the fixed 640x480 divider/sync/painter chain.

---
 rtl/vga_timing_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_vga_timing_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with a LAT-tick request-to-colour pipeline.
// Optional VGA_TEST_PATTERN_EN adds a test_mode input selecting eight vertical colour bars.
module vga_timing_pipe #(
    parameter  int unsigned CLK_DIV  = 2,
    parameter  int unsigned H_ACTIVE = 640,
    parameter  int unsigned H_FP     = 16,
    parameter  int unsigned H_SYNC   = 96,
    parameter  int unsigned H_BP     = 48,
    parameter  int unsigned V_ACTIVE = 480,
    parameter  int unsigned V_FP     = 10,
    parameter  int unsigned V_SYNC   = 2,
    parameter  int unsigned V_BP     = 33,
    parameter  int unsigned HS_POL   = 0,
    parameter  int unsigned VS_POL   = 0,
    parameter  int unsigned LAT      = 2,
    parameter  int unsigned CW       = 8,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic            test_mode,
`endif
    output logic            pix_ce,
    output logic            req_valid,
    output logic [HW-1:0]   req_x,
    output logic [VW-1:0]   req_y,
    input  logic [3*CW-1:0] rgb_in,
    output logic [CW-1:0]   red,
    output logic [CW-1:0]   green,
    output logic [CW-1:0]   blue,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_blank_n,
    output logic            vga_sync_n,
    output logic            line_start,
    output logic            frame_start
);

    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    localparam logic        HS_ACT   = 1'(HS_POL);
    localparam logic        VS_ACT   = 1'(VS_POL);
`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
`endif

    // Per-position timing that travels alongside the application's colour latency
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vis;
        logic       h0;
        logic       v0;
`ifdef VGA_TEST_PATTERN_EN
        logic       tm;
        logic [2:0] bar;
`endif
    } tim_t;

    logic [DW-1:0]   div_q, div_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic            pix_ce_q, pix_ce_d;
    logic            req_valid_q, req_valid_d;
    logic [HW-1:0]   req_x_q, req_x_d;
    logic [VW-1:0]   req_y_q, req_y_d;
    tim_t            pipe_q [0:LAT];
    tim_t            pipe_d [0:LAT];
    logic [CW-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic            hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic            ls_q, ls_d, fs_q, fs_d;
    logic            tick_c;
    tim_t            st0_c, out_c;
    logic [3*CW-1:0] colour_c;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]      bar_idx_c;
`endif

    // Next-state: divider, raster counters, request stage, timing pipe, output stage
    always_comb begin
        tick_c      = enable && (div_q == DW'(CLK_DIV - 1));
        div_d       = div_q;
        h_d         = h_q;
        v_d         = v_q;
        pix_ce_d    = 1'b0;
        req_valid_d = req_valid_q;
        req_x_d     = req_x_q;
        req_y_d     = req_y_q;
        for (int i = 0; i <= int'(LAT); i++) pipe_d[i] = pipe_q[i];
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        blank_n_d   = blank_n_q;
        ls_d        = 1'b0;
        fs_d        = 1'b0;
        out_c       = pipe_q[LAT];
        colour_c    = '0;

        st0_c     = '0;
        st0_c.hs  = (h_q >= HW'(HS_START)) && (h_q <= HW'(HS_END));
        st0_c.vs  = (v_q >= VW'(VS_START)) && (v_q <= VW'(VS_END));
        st0_c.vis = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        st0_c.h0  = (h_q == '0);
        st0_c.v0  = (v_q == '0);
`ifdef VGA_TEST_PATTERN_EN
        bar_idx_c = (h_q >= HW'(H_ACTIVE)) ? 3'd7 : 3'(h_q / HW'(BAR_W));
        st0_c.tm  = test_mode;
        st0_c.bar = {~bar_idx_c[1], ~bar_idx_c[2], ~bar_idx_c[0]};
`endif

        if (out_c.vis) begin
`ifdef VGA_TEST_PATTERN_EN
            if (out_c.tm) colour_c = {{CW{out_c.bar[2]}}, {CW{out_c.bar[1]}}, {CW{out_c.bar[0]}}};
            else          colour_c = rgb_in;
`else
            colour_c = rgb_in;
`endif
        end

        if (!enable) begin
            div_d       = '0;
            h_d         = '0;
            v_d         = '0;
            req_valid_d = 1'b0;
            req_x_d     = '0;
            req_y_d     = '0;
            for (int i = 0; i <= int'(LAT); i++) pipe_d[i] = '0;
            red_d       = '0;
            green_d     = '0;
            blue_d      = '0;
            hs_d        = ~HS_ACT;
            vs_d        = ~VS_ACT;
            blank_n_d   = 1'b0;
        end else begin
            div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
            if (tick_c) begin
                pix_ce_d = 1'b1;
                if (h_q == HW'(H_TOTAL - 1)) begin
                    h_d = '0;
                    v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                end
                req_x_d     = h_q;
                req_y_d     = v_q;
                req_valid_d = st0_c.vis;
                pipe_d[0]   = st0_c;
                for (int i = 1; i <= int'(LAT); i++) pipe_d[i] = pipe_q[i-1];
                {red_d, green_d, blue_d} = colour_c;
                hs_d        = out_c.hs ? HS_ACT : ~HS_ACT;
                vs_d        = out_c.vs ? VS_ACT : ~VS_ACT;
                blank_n_d   = out_c.vis;
                ls_d        = out_c.h0;
                fs_d        = out_c.h0 && out_c.v0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            pix_ce_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_x_q     <= '0;
            req_y_q     <= '0;
            for (int i = 0; i <= int'(LAT); i++) pipe_q[i] <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hs_q        <= ~HS_ACT;
            vs_q        <= ~VS_ACT;
            blank_n_q   <= 1'b0;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            pix_ce_q    <= pix_ce_d;
            req_valid_q <= req_valid_d;
            req_x_q     <= req_x_d;
            req_y_q     <= req_y_d;
            for (int i = 0; i <= int'(LAT); i++) pipe_q[i] <= pipe_d[i];
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_n_q   <= blank_n_d;
            ls_q        <= ls_d;
            fs_q        <= fs_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign req_valid   = req_valid_q;
    assign req_x       = req_x_q;
    assign req_y       = req_y_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Self-checking bench for vga_timing_pipe on a reduced 24x13 raster with CLK_DIV=2, LAT=2.
module tb_vga_timing_pipe;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3;
    localparam int unsigned V_ACT = 8, V_FP = 1, V_SY = 2, V_BP = 2;
    localparam int unsigned LAT = 2;
    localparam int unsigned H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int unsigned FRAME_CLK = H_TOT * V_TOT * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pix_ce, req_valid;
    logic [4:0]  req_x;
    logic [3:0]  req_y;
    logic [23:0] rgb_in;
    logic [7:0]  red, green, blue;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, line_start, frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    vga_timing_pipe #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(0), .LAT(LAT), .CW(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pix_ce(pix_ce), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .rgb_in(rgb_in), .red(red), .green(green), .blue(blue),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Application model: colour = {x, y, A5} of the request shown LAT ticks earlier
    logic [4:0] px, h1x, h2x;
    logic [3:0] py, h1y, h2y;
    assign rgb_in = {8'(h2x), 8'(h2y), 8'hA5};
    always @(negedge clk) begin
        if (!reset || !enable) begin
            px <= '0; h1x <= '0; h2x <= '0; py <= '0; h1y <= '0; h2y <= '0;
        end else if (pix_ce) begin
            h2x <= h1x; h1x <= px; px <= req_x;
            h2y <= h1y; h1y <= py; py <= req_y;
        end
    end

    typedef struct {
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       ls;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rec_t;

    function automatic rec_t model(input int x, input int y);
        rec_t e;
        logic vis;
        vis  = (x < int'(H_ACT)) && (y < int'(V_ACT));
        e.x  = x;
        e.y  = y;
        e.hs = !((x >= int'(H_ACT + H_FP)) && (x < int'(H_ACT + H_FP + H_SY)));
        e.vs = !((y >= int'(V_ACT + V_FP)) && (y < int'(V_ACT + V_FP + V_SY)));
        e.bn = vis;
        e.ls = (x == 0);
        e.fs = (x == 0) && (y == 0);
        e.r  = vis ? 8'(x) : 8'h00;
        e.g  = vis ? 8'(y) : 8'h00;
        e.b  = vis ? 8'hA5 : 8'h00;
        return e;
    endfunction

    // Scoreboard monitor: push expectation at each request, pop when its output emerges
    bit   mon_en = 1'b0;
    rec_t q [$];
    rec_t obs [0:V_TOT-1][0:H_TOT-1];
    int   bx, by, gap, fclk, bcnt, frames = 0;
    bit   have_prev, seen_ce, seen_fs;
    logic [42:0] prev_v;

    always @(negedge clk) begin
        rec_t e, o;
        logic [42:0] cur_v;
        cur_v = {red, green, blue, vga_hs, vga_vs, vga_blank_n, req_x, req_y, req_valid, vga_sync_n};
        if (!mon_en) begin
            q.delete();
            bx = 0; by = 0; gap = 0; fclk = 0; bcnt = 0;
            have_prev = 0; seen_ce = 0; seen_fs = 0;
        end else begin
            gap++;
            fclk++;
            if (pix_ce) begin
                if (seen_ce) check("pix_ce_gap", gap, CLK_DIV);
                seen_ce = 1; gap = 0;
                check("req_x", 32'(req_x), bx);
                check("req_y", 32'(req_y), by);
                check("req_valid", 32'(req_valid), 32'((bx < int'(H_ACT)) && (by < int'(V_ACT))));
                q.push_back(model(bx, by));
                if (q.size() > int'(LAT) + 1) begin
                    e = q.pop_front();
                    check("hs", 32'(vga_hs), 32'(e.hs));
                    check("vs", 32'(vga_vs), 32'(e.vs));
                    check("blank_n", 32'(vga_blank_n), 32'(e.bn));
                    check("line_start", 32'(line_start), 32'(e.ls));
                    check("frame_start", 32'(frame_start), 32'(e.fs));
                    check("red", 32'(red), 32'(e.r));
                    check("green", 32'(green), 32'(e.g));
                    check("blue", 32'(blue), 32'(e.b));
                    o = e;
                    o.hs = vga_hs; o.vs = vga_vs; o.bn = vga_blank_n; o.ls = line_start;
                    o.fs = frame_start; o.r = red; o.g = green; o.b = blue;
                    obs[e.y][e.x] = o;
                end
                bx++;
                if (bx == int'(H_TOT)) begin
                    bx = 0;
                    by = (by == int'(V_TOT) - 1) ? 0 : by + 1;
                end
                if (frame_start) begin
                    if (seen_fs) begin
                        check("frame_clks", fclk, FRAME_CLK);
                        check("visible_per_frame", bcnt, H_ACT * V_ACT);
                    end
                    seen_fs = 1; fclk = 0; bcnt = 0;
                    frames++;
                end
                if (vga_blank_n) bcnt++;
            end else if (have_prev) begin
                check("hold_between_ticks", cur_v, prev_v);
                check("pulse_width", 32'({line_start, frame_start}), 0);
            end
            have_prev = 1;
            prev_v = cur_v;
        end
    end

    task automatic startup_check(input string tag);
        int  n = 0, ticks = 0;
        bit  got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (pix_ce) got = 1;
        end
        check({tag, "_first_ce_clks"}, n, CLK_DIV);
        check({tag, "_first_req"}, 32'({req_valid, req_x, req_y}), 32'({1'b1, 5'd0, 4'd0}));
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (pix_ce) ticks++;
            if (frame_start) got = 1;
        end
        check({tag, "_frame_start_ticks"}, ticks, LAT + 1);
        check({tag, "_fs_outputs"}, 32'({vga_blank_n, line_start, red}), 32'({1'b1, 1'b1, 8'h00}));
    endtask

    task automatic wait_pos(input int x, input int y);
        bit got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (pix_ce && int'(req_x) == x && int'(req_y) == y) got = 1;
        end
        check("wait_pos_timeout", 32'(got), 1);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 4 * int'(FRAME_CLK) && frames < n; i++) @(negedge clk);
        check("wait_frames_timeout", 32'(frames >= n), 1);
    endtask

    typedef struct {
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
    } vec_t;

    vec_t tbl [12];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({pix_ce, req_valid, vga_blank_n, line_start, frame_start, vga_sync_n}), 0);
        check({tag, "_sync"}, 32'({vga_hs, vga_vs}), 32'(2'b11));
        check({tag, "_req"}, 32'({req_x, req_y}), 0);
        check({tag, "_rgb"}, 32'({red, green, blue}), 0);
    endtask

    initial begin
        tbl[0]  = '{x: 0,  y: 0,  hs: 1, vs: 1, bn: 1, r: 8'd0,  g: 8'd0};
        tbl[1]  = '{x: 15, y: 7,  hs: 1, vs: 1, bn: 1, r: 8'd15, g: 8'd7};
        tbl[2]  = '{x: 9,  y: 4,  hs: 1, vs: 1, bn: 1, r: 8'd9,  g: 8'd4};
        tbl[3]  = '{x: 16, y: 0,  hs: 1, vs: 1, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[4]  = '{x: 17, y: 3,  hs: 1, vs: 1, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[5]  = '{x: 18, y: 3,  hs: 0, vs: 1, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[6]  = '{x: 20, y: 3,  hs: 0, vs: 1, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[7]  = '{x: 21, y: 3,  hs: 1, vs: 1, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[8]  = '{x: 5,  y: 8,  hs: 1, vs: 1, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[9]  = '{x: 5,  y: 9,  hs: 1, vs: 0, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[10] = '{x: 23, y: 10, hs: 1, vs: 0, bn: 0, r: 8'd0,  g: 8'd0};
        tbl[11] = '{x: 10, y: 11, hs: 1, vs: 1, bn: 0, r: 8'd0,  g: 8'd0};

        reset  = 1'b1;
        enable = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        // Released but idle: enable low must keep everything at rest
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle");

        enable = 1'b1;
        mon_en = 1'b1;
        startup_check("start");
        wait_frames(3);

        foreach (tbl[i]) begin
            rec_t o;
            o = obs[tbl[i].y][tbl[i].x];
            check($sformatf("tbl%0d_hs", i), 32'(o.hs), 32'(tbl[i].hs));
            check($sformatf("tbl%0d_vs", i), 32'(o.vs), 32'(tbl[i].vs));
            check($sformatf("tbl%0d_blank_n", i), 32'(o.bn), 32'(tbl[i].bn));
            check($sformatf("tbl%0d_red", i), 32'(o.r), 32'(tbl[i].r));
            check($sformatf("tbl%0d_green", i), 32'(o.g), 32'(tbl[i].g));
        end

        // Asynchronous reset in the middle of a visible line
        wait_pos(10, 5);
        check("pre_reset_visible", 32'({vga_blank_n, red}), 32'({1'b1, 8'd7}));
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset_hold");
        reset  = 1'b1;
        mon_en = 1'b1;
        startup_check("rst_release");
        frames = 0;
        wait_frames(2);

        // Enable dropped for 10 clocks mid-line
        wait_pos(7, 3);
        mon_en = 1'b0;
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outputs("disabled");
        enable = 1'b1;
        mon_en = 1'b1;
        startup_check("reenable");
        frames = 0;
        wait_frames(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
